// File: rtl/core_defs_pkg.sv
// Shared core definitions: datapath widths, hazard timing tags and the NOP word.
package core_defs_pkg;

   localparam int unsigned DATA_W    = 32;
   localparam int unsigned TNEW_W    = 2;
   localparam int unsigned BUB_CNT_W = 16;
   localparam int unsigned A3_W      = 5;

   // Tnew values are counted from the D stage
   localparam logic [TNEW_W-1:0] TNEW_ALU  = 2'd1;
   localparam logic [TNEW_W-1:0] TNEW_LOAD = 2'd2;

   localparam logic [DATA_W-1:0] NOP_WORD = 32'h0000_0000;

endpackage : core_defs_pkg

// File: rtl/pipe_field_reg.sv
// One pipeline field: synchronous reset to zero, clear loads clr_val, enable loads d.
module pipe_field_reg #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] d,
   input  logic [W-1:0] clr_val,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else if (clr) begin
         q <= clr_val;
      end else if (en) begin
         q <= d;
      end
   end

endmodule : pipe_field_reg

// File: rtl/d_e_pipe_reg.sv
// D->E pipeline register: captures decoded operands, inserts bubbles on clear,
// and counts inserted bubbles with a saturating counter.
module d_e_pipe_reg
   import core_defs_pkg::*;
#(
   parameter int unsigned DW   = DATA_W,
   parameter int unsigned TW   = TNEW_W,
   parameter int unsigned CNTW = BUB_CNT_W
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            D_E_en,
   input  logic            D_E_clr,
   input  logic [DW-1:0]   D_PC,
   input  logic [DW-1:0]   D_instr,
   input  logic [DW-1:0]   D_rs_data,
   input  logic [DW-1:0]   D_rt_data,
   input  logic [DW-1:0]   D_EXT_imm32,
   input  logic [A3_W-1:0] D_A3,
   input  logic [TW-1:0]   D_Tnew,
   output logic [DW-1:0]   E_PC,
   output logic [DW-1:0]   E_PC8,
   output logic [DW-1:0]   E_instr,
   output logic [DW-1:0]   E_rs_data,
   output logic [DW-1:0]   E_rt_data,
   output logic [DW-1:0]   E_imm32,
   output logic [A3_W-1:0] E_A3,
   output logic [TW-1:0]   E_Tnew,
   output logic            E_valid,
   output logic [CNTW-1:0] bubble_cnt
);

   logic [DW-1:0] pc8;
   logic [TW-1:0] tnew_e;

   // A write to $0 carries no timing tag, so forwarding can never match it
   always_comb begin
      pc8    = D_PC + DW'(8);
      tnew_e = '0;
      if (D_A3 != '0 && D_Tnew != '0) begin
         tnew_e = D_Tnew - TW'(1);
      end
   end

   pipe_field_reg #(.W(DW)) u_pc (
      .clk(clk), .reset(reset), .en(D_E_en), .clr(D_E_clr),
      .d(D_PC), .clr_val(D_PC), .q(E_PC));

   pipe_field_reg #(.W(DW)) u_pc8 (
      .clk(clk), .reset(reset), .en(D_E_en), .clr(D_E_clr),
      .d(pc8), .clr_val(pc8), .q(E_PC8));

   pipe_field_reg #(.W(DW)) u_instr (
      .clk(clk), .reset(reset), .en(D_E_en), .clr(D_E_clr),
      .d(D_instr), .clr_val(DW'(NOP_WORD)), .q(E_instr));

   pipe_field_reg #(.W(DW)) u_rs (
      .clk(clk), .reset(reset), .en(D_E_en), .clr(D_E_clr),
      .d(D_rs_data), .clr_val('0), .q(E_rs_data));

   pipe_field_reg #(.W(DW)) u_rt (
      .clk(clk), .reset(reset), .en(D_E_en), .clr(D_E_clr),
      .d(D_rt_data), .clr_val('0), .q(E_rt_data));

   pipe_field_reg #(.W(DW)) u_imm (
      .clk(clk), .reset(reset), .en(D_E_en), .clr(D_E_clr),
      .d(D_EXT_imm32), .clr_val('0), .q(E_imm32));

   pipe_field_reg #(.W(A3_W)) u_a3 (
      .clk(clk), .reset(reset), .en(D_E_en), .clr(D_E_clr),
      .d(D_A3), .clr_val('0), .q(E_A3));

   pipe_field_reg #(.W(TW)) u_tnew (
      .clk(clk), .reset(reset), .en(D_E_en), .clr(D_E_clr),
      .d(tnew_e), .clr_val('0), .q(E_Tnew));

   pipe_field_reg #(.W(1)) u_valid (
      .clk(clk), .reset(reset), .en(D_E_en), .clr(D_E_clr),
      .d(1'b1), .clr_val(1'b0), .q(E_valid));

   // Saturating bubble counter; reset takes precedence over a concurrent stall
   always_ff @(posedge clk) begin
      if (reset) begin
         bubble_cnt <= '0;
      end else if (D_E_clr && bubble_cnt != '1) begin
         bubble_cnt <= bubble_cnt + CNTW'(1);
      end
   end

endmodule : d_e_pipe_reg

// File: tb/tb_d_e_pipe_reg.sv
// Self-checking bench for d_e_pipe_reg: directed steps plus randomized traffic
// compared against a field-level reference model; a second instance uses a 2-bit counter.
module tb_d_e_pipe_reg;

   logic        clk = 1'b0;
   logic        reset, en, clr;
   logic [31:0] d_pc, d_instr, d_rs, d_rt, d_imm;
   logic [4:0]  d_a3;
   logic [1:0]  d_tnew;

   logic [31:0] e_pc, e_pc8, e_instr, e_rs, e_rt, e_imm;
   logic [4:0]  e_a3;
   logic [1:0]  e_tnew;
   logic        e_valid;
   logic [15:0] bcnt;

   logic [31:0] s_pc, s_pc8, s_instr, s_rs, s_rt, s_imm;
   logic [4:0]  s_a3;
   logic [1:0]  s_tnew;
   logic        s_valid;
   logic [1:0]  bcnt2;

   // Reference state
   logic [31:0] m_pc, m_pc8, m_instr, m_rs, m_rt, m_imm;
   logic [4:0]  m_a3;
   int          m_tnew, m_valid, m_cnt, m_cnt2;

   int n_pass = 0;
   int n_checks = 0;

   always #5 clk = ~clk;

   d_e_pipe_reg dut (
      .clk(clk), .reset(reset), .D_E_en(en), .D_E_clr(clr),
      .D_PC(d_pc), .D_instr(d_instr), .D_rs_data(d_rs), .D_rt_data(d_rt),
      .D_EXT_imm32(d_imm), .D_A3(d_a3), .D_Tnew(d_tnew),
      .E_PC(e_pc), .E_PC8(e_pc8), .E_instr(e_instr), .E_rs_data(e_rs),
      .E_rt_data(e_rt), .E_imm32(e_imm), .E_A3(e_a3), .E_Tnew(e_tnew),
      .E_valid(e_valid), .bubble_cnt(bcnt));

   d_e_pipe_reg #(.CNTW(2)) dut_sat (
      .clk(clk), .reset(reset), .D_E_en(en), .D_E_clr(clr),
      .D_PC(d_pc), .D_instr(d_instr), .D_rs_data(d_rs), .D_rt_data(d_rt),
      .D_EXT_imm32(d_imm), .D_A3(d_a3), .D_Tnew(d_tnew),
      .E_PC(s_pc), .E_PC8(s_pc8), .E_instr(s_instr), .E_rs_data(s_rs),
      .E_rt_data(s_rt), .E_imm32(s_imm), .E_A3(s_a3), .E_Tnew(s_tnew),
      .E_valid(s_valid), .bubble_cnt(bcnt2));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Reference update applied at each clock edge from the inputs the DUT sees
   task automatic model_edge();
      if (reset) begin
         m_pc = 0; m_pc8 = 0; m_instr = 0; m_rs = 0; m_rt = 0; m_imm = 0;
         m_a3 = 0; m_tnew = 0; m_valid = 0; m_cnt = 0; m_cnt2 = 0;
      end else if (clr) begin
         m_pc = d_pc; m_pc8 = d_pc + 32'd8;
         m_instr = 0; m_rs = 0; m_rt = 0; m_imm = 0;
         m_a3 = 0; m_tnew = 0; m_valid = 0;
         m_cnt  = (m_cnt  + 1 > 65535) ? 65535 : m_cnt + 1;
         m_cnt2 = (m_cnt2 + 1 > 3)     ? 3     : m_cnt2 + 1;
      end else if (en) begin
         m_pc = d_pc; m_pc8 = d_pc + 32'd8;
         m_instr = d_instr; m_rs = d_rs; m_rt = d_rt; m_imm = d_imm;
         m_a3 = d_a3;
         m_tnew = (d_a3 == 0) ? 0 : ((int'(d_tnew) > 0) ? int'(d_tnew) - 1 : 0);
         m_valid = 1;
      end
   endtask

   task automatic check_all();
      chk("E_PC",       64'(e_pc),    64'(m_pc));
      chk("E_PC8",      64'(e_pc8),   64'(m_pc8));
      chk("E_instr",    64'(e_instr), 64'(m_instr));
      chk("E_rs_data",  64'(e_rs),    64'(m_rs));
      chk("E_rt_data",  64'(e_rt),    64'(m_rt));
      chk("E_imm32",    64'(e_imm),   64'(m_imm));
      chk("E_A3",       64'(e_a3),    64'(m_a3));
      chk("E_Tnew",     64'(e_tnew),  64'(m_tnew));
      chk("E_valid",    64'(e_valid), 64'(m_valid));
      chk("bubble_cnt", 64'(bcnt),    64'(m_cnt));
      chk("bubble_cnt_sat", 64'(bcnt2), 64'(m_cnt2));
   endtask

   // Apply controls, clock once, then check one time unit after the edge
   task automatic step(input logic r, input logic e, input logic c);
      reset = r; en = e; clr = c;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic set_d(input logic [31:0] pc, input logic [31:0] ins,
                        input logic [31:0] imm, input logic [4:0] a3, input logic [1:0] tn);
      d_pc = pc; d_instr = ins; d_imm = imm; d_a3 = a3; d_tnew = tn;
      d_rs = $urandom; d_rt = $urandom;
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; clr = 1'b0;
      set_d(32'h0, 32'h0, 32'h0, 5'd0, 2'd0);
      m_pc = 0; m_pc8 = 0; m_instr = 0; m_rs = 0; m_rt = 0; m_imm = 0;
      m_a3 = 0; m_tnew = 0; m_valid = 0; m_cnt = 0; m_cnt2 = 0;
      @(negedge clk);

      // Reset for two cycles, then idle
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("reset_valid", 64'(e_valid), 64'(0));
      chk("reset_cnt",   64'(bcnt),    64'(0));

      // Basic load of an ALU instruction
      set_d(32'h3000, 32'h3402_1234, 32'h0000_1234, 5'd2, 2'd1);
      step(1'b0, 1'b1, 1'b0);
      chk("load_pc8",   64'(e_pc8),   64'(32'h3008));
      chk("load_tnew",  64'(e_tnew),  64'(0));
      chk("load_a3",    64'(e_a3),    64'(2));
      chk("load_valid", 64'(e_valid), 64'(1));

      // Load then hold for three cycles while D changes
      set_d(32'h3004, 32'h8c43_0004, 32'h0000_0004, 5'd3, 2'd2);
      step(1'b0, 1'b1, 1'b0);
      set_d(32'h3008, 32'hdead_beef, 32'h1111_2222, 5'd7, 2'd3);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b0);
         chk("hold_tnew", 64'(e_tnew), 64'(1));
         chk("hold_pc",   64'(e_pc),   64'(32'h3004));
      end

      // Clear wins over enable and keeps the PC
      set_d(32'h3010, 32'h0123_4567, 32'h89ab_cdef, 5'd9, 2'd2);
      step(1'b0, 1'b1, 1'b1);
      chk("bubble_instr", 64'(e_instr), 64'(0));
      chk("bubble_a3",    64'(e_a3),    64'(0));
      chk("bubble_valid", 64'(e_valid), 64'(0));
      chk("bubble_pc",    64'(e_pc),    64'(32'h3010));
      chk("bubble_cnt1",  64'(bcnt),    64'(1));

      // Write to $0 suppresses Tnew; PC+8 wraps
      set_d(32'h3014, 32'h2400_0005, 32'h0000_0005, 5'd0, 2'd2);
      step(1'b0, 1'b1, 1'b0);
      chk("a3zero_a3",   64'(e_a3),   64'(0));
      chk("a3zero_tnew", 64'(e_tnew), 64'(0));
      set_d(32'hFFFF_FFFC, 32'h0000_0000, 32'h0, 5'd31, 2'd0);
      step(1'b0, 1'b1, 1'b0);
      chk("pc8_wrap", 64'(e_pc8), 64'(32'h0000_0004));

      // Saturation of a 2-bit counter, then reset during a stall
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 1'b1);
         chk("sat_seq", 64'(bcnt2), 64'((i < 3) ? i + 1 : 3));
      end
      step(1'b1, 1'b0, 1'b1);
      chk("reset_in_stall", 64'(bcnt2), 64'(0));
      chk("reset_in_stall16", 64'(bcnt), 64'(0));

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         d_pc    = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                              : $urandom;
         d_instr = $urandom; d_rs = $urandom; d_rt = $urandom; d_imm = $urandom;
         d_a3    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         d_tnew  = 2'($urandom);
         step(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 6),
              ($urandom_range(0, 4) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_d_e_pipe_reg
